// File: rtl/fetch_unit.sv
// fetch_unit: PC, IR and status register datapath answering the SISC control FSM strobes
//   in : clk, rst_f (sync reset), pc_rst, pc_write, pc_sel, br_sel, ir_load, stat_we, alu_stat {C,N,V,Z}, imem_data
//   out: imem_addr (= PC), instr (= IR), opcode, mm, stat, br_taken, illegal (sticky)
module fetch_unit #(
   parameter int PC_W = 16,
   parameter int IW   = 32
) (
   input  logic            clk,
   input  logic            rst_f,
   input  logic            pc_rst,
   input  logic            pc_write,
   input  logic            pc_sel,
   input  logic            br_sel,
   input  logic            ir_load,
   input  logic            stat_we,
   input  logic [3:0]      alu_stat,
   input  logic [IW-1:0]   imem_data,
   output logic [PC_W-1:0] imem_addr,
   output logic [IW-1:0]   instr,
   output logic [3:0]      opcode,
   output logic [3:0]      mm,
   output logic [3:0]      stat,
   output logic            br_taken,
   output logic            illegal
);
   logic [PC_W-1:0] r_pc, w_inc, w_tgt;
   logic [IW-1:0]   r_ir;
   logic [3:0]      r_stat;
   logic            r_illegal, w_hit, w_bad;
   always_comb begin
      w_inc    = r_pc + PC_W'(1);
      // relative offset is the sign-extended 16-bit immediate; absolute target is the raw immediate
      w_tgt    = br_sel ? PC_W'(r_ir[15:0]) : w_inc + PC_W'(signed'(r_ir[15:0]));
      w_hit    = |(r_stat & r_ir[IW-5 -: 4]);
      w_bad    = imem_data[IW-1 -: 4] inside {[4'd9:4'd14]};
      br_taken = (r_ir[IW-1 -: 4] inside {4'd4, 4'd5}) ? w_hit :
                 (r_ir[IW-1 -: 4] inside {4'd6, 4'd7}) ? ~w_hit : 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst_f) begin
         r_pc      <= '0;
         r_ir      <= '0;
         r_stat    <= '0;
         r_illegal <= 1'b0;
      end else begin
         if (pc_rst)
            r_pc <= '0;
         else if (pc_write)
            r_pc <= pc_sel ? w_tgt : w_inc;
         if (ir_load)
            r_ir <= imem_data;
         if (stat_we)
            r_stat <= alu_stat;
         if (ir_load && w_bad)
            r_illegal <= 1'b1;
      end
   end
   assign imem_addr = r_pc;
   assign instr     = r_ir;
   assign opcode    = r_ir[IW-1 -: 4];
   assign mm        = r_ir[IW-5 -: 4];
   assign stat      = r_stat;
   assign illegal   = r_illegal;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan plus random strobes checked against a behavioural model
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_f = 1'b1, pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
   logic        ir_load = 1'b0, stat_we = 1'b0;
   logic [3:0]  alu_stat = '0;
   logic [31:0] imem_data = '0;
   logic [15:0] imem_addr;
   logic [31:0] instr;
   logic [3:0]  opcode, mm, stat;
   logic        br_taken, illegal;
   int          n_chk = 0, n_pass = 0;
   int          m_pc = 0, m_stat = 0;
   logic [31:0] m_ir = '0;
   bit          m_ill = 0;
   fetch_unit dut (
      .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
      .br_sel(br_sel), .ir_load(ir_load), .stat_we(stat_we), .alu_stat(alu_stat),
      .imem_data(imem_data), .imem_addr(imem_addr), .instr(instr), .opcode(opcode),
      .mm(mm), .stat(stat), .br_taken(br_taken), .illegal(illegal)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   function automatic bit br_ref(int op, int msk, int st);
      int hit = st & msk;
      if (op == 4 || op == 5) return hit != 0;
      if (op == 6 || op == 7) return hit == 0;
      return 0;
   endfunction
   task automatic step();
      int imm, n_pc, op;
      imm  = int'(m_ir[15:0]);
      if (imm >= 32768) imm -= 65536;
      n_pc = m_pc;
      if (rst_f || pc_rst) n_pc = 0;
      else if (pc_write)
         n_pc = !pc_sel ? (m_pc + 1) % 65536 :
                br_sel  ? int'(m_ir[15:0]) :
                          ((m_pc + 1 + imm) % 65536 + 65536) % 65536;
      op = int'(imem_data[31:28]);
      @(posedge clk);
      m_pc = n_pc;
      if (rst_f) begin
         m_ir = '0; m_stat = 0; m_ill = 0;
      end else begin
         if (ir_load && op >= 9 && op <= 14) m_ill = 1;
         if (ir_load) m_ir = imem_data;
         if (stat_we) m_stat = int'(alu_stat);
      end
      #1;
      chk("pc", 32'(imem_addr), 32'(m_pc));
      chk("ir", instr, m_ir);
      chk("opcode", 32'(opcode), 32'(m_ir[31:28]));
      chk("mm", 32'(mm), 32'(m_ir[27:24]));
      chk("stat", 32'(stat), 32'(m_stat));
      chk("br_taken", 32'(br_taken), 32'(br_ref(int'(m_ir[31:28]), int'(m_ir[27:24]), m_stat)));
      chk("illegal", 32'(illegal), 32'(m_ill));
   endtask
   task automatic cyc(input logic rf, pr, pw, ps, bs, il, sw, input logic [3:0] as, input logic [31:0] d);
      rst_f = rf; pc_rst = pr; pc_write = pw; pc_sel = ps; br_sel = bs;
      ir_load = il; stat_we = sw; alu_stat = as; imem_data = d;
      step();
   endtask
   initial begin
      // reset held with pc_write active
      cyc(1, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0);
      cyc(1, 0, 1, 0, 0, 1, 1, 4'hF, 32'h9000_0000);
      chk("pc_in_reset", 32'(imem_addr), 32'h0);
      // sequential increments
      repeat (3) cyc(0, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0);
      chk("pc_after_3", 32'(imem_addr), 32'h3);
      // preload 0xFFFF by absolute jump, then wrap
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0000_FFFF);
      cyc(0, 0, 1, 1, 1, 0, 0, 4'h0, 32'h0);
      cyc(0, 0, 1, 0, 0, 0, 0, 4'h0, 32'h0);
      chk("pc_wrap", 32'(imem_addr), 32'h0);
      // PC=0x10, BRR mm=1 with Z set, relative +3 and -2
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0000_0010);
      cyc(0, 0, 1, 1, 1, 0, 0, 4'h0, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 1, 4'h1, 32'h5100_0003);
      chk("brr_taken", 32'(br_taken), 32'h1);
      cyc(0, 0, 1, 1, 0, 0, 0, 4'h0, 32'h0);
      chk("brr_pos", 32'(imem_addr), 32'h14);
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0000_0010);
      cyc(0, 0, 1, 1, 1, 0, 0, 4'h0, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h5100_FFFE);
      cyc(0, 0, 1, 1, 0, 0, 0, 4'h0, 32'h0);
      chk("brr_neg", 32'(imem_addr), 32'hF);
      // BNE mm=2
      cyc(0, 0, 0, 0, 0, 1, 1, 4'h2, 32'h6200_0040);
      chk("bne_nt", 32'(br_taken), 32'h0);
      cyc(0, 0, 0, 0, 0, 0, 1, 4'h1, 32'h0);
      chk("bne_t", 32'(br_taken), 32'h1);
      // branch uses old stat while a new stat is written in the same edge
      cyc(0, 0, 1, 1, 1, 0, 1, 4'h2, 32'h0);
      chk("bne_abs", 32'(imem_addr), 32'h40);
      // get PC to 7, then load + advance together
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0000_0007);
      cyc(0, 0, 1, 1, 1, 0, 0, 4'h0, 32'h0);
      cyc(0, 0, 1, 0, 0, 1, 0, 4'h0, 32'h8100_0000);
      chk("ir_old_pc", instr, 32'h8100_0000);
      chk("pc_adv", 32'(imem_addr), 32'h8);
      cyc(0, 1, 1, 0, 0, 0, 0, 4'h0, 32'h0);
      chk("pc_rst_wins", 32'(imem_addr), 32'h0);
      // illegal opcode is sticky until reset
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'hA000_0000);
      chk("illegal_set", 32'(illegal), 32'h1);
      cyc(0, 0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
      cyc(0, 0, 0, 0, 0, 1, 0, 4'hF, 32'hF000_0000);
      chk("illegal_sticky", 32'(illegal), 32'h1);
      cyc(1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
      chk("illegal_clr", 32'(illegal), 32'h0);
      // random strobes
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Datapath-side responder to the SISC control FSM's strobes (pc_rst, pc_write, pc_sel, br_sel, ir_load).
- Owns the program counter, instruction register and status register.
- Returns opcode/mm/stat fields plus a branch-condition result to the FSM, and drives the instruction memory address.
- Sits between the control FSM, instruction memory and the ALU status outputs.

Parameters:
- PC_W, 16, program counter and instruction memory address width.
- IW, 32, instruction width. Fields: opcode [31:28], mm [27:24], imm [15:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_f  input  1  synchronous, active-high reset.
- pc_rst  input  1  synchronous clear of PC to 0.
- pc_write  input  1  PC update enable.
- pc_sel  input  1  0: PC <= PC+1; 1: PC <= branch target.
- br_sel  input  1  0: relative target (PC+1+imm); 1: absolute target (imm).
- ir_load  input  1  capture imem_data into IR.
- stat_we  input  1  capture alu_stat into status register.
- alu_stat  input  4  ALU flags {C,N,V,Z} (bit3..bit0).
- imem_data  input  IW  instruction word at imem_addr (combinational read).
- imem_addr  output  PC_W  equals the PC register.
- instr  output  IW  IR contents.
- opcode  output  4  IR[31:28].
- mm  output  4  IR[27:24].
- stat  output  4  status register.
- br_taken  output  1  branch condition for the current IR (combinational).
- illegal  output  1  sticky flag: undefined opcode was loaded.

Behaviour:
- Reset: when rst_f=1 at a rising edge, PC=0, IR=0 (NOOP), stat=0 and illegal=0. It overrides every other input and takes effect in the same edge, including mid-branch.
- PC priority per edge: rst_f > pc_rst > pc_write > hold.
- pc_write with pc_sel=0: PC <= PC+1 mod 2^PC_W. 0xFFFF wraps to 0x0000.
- pc_write with pc_sel=1, br_sel=0: PC <= PC+1+imm mod 2^PC_W. imm is treated as two's-complement 16-bit.
- pc_write with pc_sel=1, br_sel=1: PC <= imm[PC_W-1:0].
- Branch targets always use the current registered PC and IR, not values being written in the same edge.
- ir_load: IR <= imem_data. imem_data corresponds to the pre-edge PC, so ir_load and pc_write in the same cycle capture the old-PC instruction and advance the PC.
- stat_we: stat <= alu_stat. Otherwise stat holds.
- br_taken is combinational from the registered IR and stat:
  - opcode 4 (BRA) or 5 (BRR): br_taken = |(stat & mm).
  - opcode 6 (BNE) or 7 (BNR): br_taken = ~|(stat & mm).
  - All other opcodes: br_taken = 0.
- stat_we in the same cycle as a branch decision: the decision uses the old stat; the new stat is visible from the next cycle.
- Defined opcodes: 0-8 and 15. On ir_load of opcode 9-14, illegal <= 1. illegal stays set until rst_f.
- No latency beyond one edge on any register: outputs reflect new state the cycle after the strobe.
- Strobes arriving with no enable change nothing. Multiple strobes in one cycle act independently per the rules above.

Test Plan:
- Reset, then hold rst_f=1 with pc_write=1 -> PC=0, IR=0, stat=0, illegal=0. PC stays 0 while rst_f=1.
- Reset, then 3 cycles of pc_write=1, pc_sel=0 -> imem_addr 0,1,2,3 on successive cycles. Preload PC=0xFFFF, one increment -> 0x0000.
- Load IR=0x5_1_00_0003 (BRR, mm=1), stat_we with alu_stat=0001 -> br_taken=1. With PC=0x0010, pc_sel=1, br_sel=0 -> PC=0x0014. Repeat with imm=0xFFFE -> PC=0x000F.
- Load IR=0x6_2_00_0040 (BNE, mm=2), stat=0010 -> br_taken=0. stat=0001 -> br_taken=1. pc_sel=1, br_sel=1 -> PC=0x0040.
- Same cycle ir_load + pc_write(pc_sel=0) at PC=7 with imem_data=0x81000000 -> IR=0x81000000 (old-PC word), PC=8. Same cycle pc_rst + pc_write -> PC=0.
- ir_load with opcode 0xA -> illegal=1. It persists across further ir_load of NOOP and clears only on rst_f.
